// File: rtl/reg_file_8x8.sv
// Purpose: 8x8-bit register file with R0 hard-wired zero, write-through read bypass and a pending-write scoreboard.
// Latency: reads are combinational (0 cycles); writes, reservations and busy_cnt update on the next rising edge.
// Backpressure: none; a write-back is accepted every cycle we is high, and issue must honour stall itself.
module reg_file_8x8 #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              resv_en,
    input  logic [ADDR_W-1:0] resv_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_busy_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_b,
    output logic              stall,
    output logic [3:0]        busy_cnt
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nxt;
    logic [3:0]        cnt_nxt;
    logic              wr_vld;
    logic              resv_vld;

    // Address 0 is never written nor reserved.
    assign wr_vld   = we && (wr_addr != '0);
    assign resv_vld = resv_en && (resv_addr != '0);

    // Next scoreboard: write-back clears, then reserve sets (newer instruction wins).
    always_comb begin
        busy_nxt = busy;
        if (wr_vld) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (resv_vld) begin
            busy_nxt[resv_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Population count of the next scoreboard so busy_cnt tracks busy in the same edge.
    always_comb begin
        cnt_nxt = 4'd0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_nxt = cnt_nxt + 4'(busy_nxt[i]);
        end
    end

    // State update: synchronous active-low reset overrides write and reserve.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy     <= '0;
            busy_cnt <= 4'd0;
        end else begin
            if (wr_vld) begin
                regs[wr_addr] <= wr_data;
            end
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // Port A read: R0 reads zero, same-cycle write-back bypasses storage and clears the hazard.
    always_comb begin
        rd_data_a = '0;
        rd_busy_a = 1'b0;
        if (rd_addr_a != '0) begin
            if (we && (wr_addr == rd_addr_a)) begin
                rd_data_a = wr_data;
                rd_busy_a = 1'b0;
            end else begin
                rd_data_a = regs[rd_addr_a];
                rd_busy_a = busy[rd_addr_a];
            end
        end
    end

    // Port B read: identical rules to port A.
    always_comb begin
        rd_data_b = '0;
        rd_busy_b = 1'b0;
        if (rd_addr_b != '0) begin
            if (we && (wr_addr == rd_addr_b)) begin
                rd_data_b = wr_data;
                rd_busy_b = 1'b0;
            end else begin
                rd_data_b = regs[rd_addr_b];
                rd_busy_b = busy[rd_addr_b];
            end
        end
    end

    assign stall = rd_busy_a | rd_busy_b;

endmodule

// File: tb/tb_reg_file_8x8.sv
module tb_reg_file_8x8;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       resv_en;
    logic [2:0] resv_addr;
    logic [2:0] rd_addr_a;
    logic [7:0] rd_data_a;
    logic       rd_busy_a;
    logic [2:0] rd_addr_b;
    logic [7:0] rd_data_b;
    logic       rd_busy_b;
    logic       stall;
    logic [3:0] busy_cnt;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [7:0] m_regs [8];
    bit         m_busy [8];

    reg_file_8x8 dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .resv_en   (resv_en),
        .resv_addr (resv_addr),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_busy_a (rd_busy_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .rd_busy_b (rd_busy_b),
        .stall     (stall),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_data(input logic [2:0] a);
        if (a == 0) return 8'h00;
        if (we && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [2:0] a);
        if (a == 0) return 1'b0;
        if (we && wr_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [3:0] exp_cnt();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(m_busy[i]);
        return 4'(n);
    endfunction

    // Model update at each rising edge from the architectural rules
    always @(posedge clk) begin
        if (rst === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                m_regs[i] = 8'h00;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (resv_en && resv_addr != 0) m_busy[resv_addr] = 1'b1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            logic ba, bb;
            ba = exp_busy(rd_addr_a);
            bb = exp_busy(rd_addr_b);
            chk("model rd_data_a", rd_data_a, exp_data(rd_addr_a));
            chk("model rd_data_b", rd_data_b, exp_data(rd_addr_b));
            chk("model rd_busy_a", {7'b0, rd_busy_a}, {7'b0, ba});
            chk("model rd_busy_b", {7'b0, rd_busy_b}, {7'b0, bb});
            chk("model stall", {7'b0, stall}, {7'b0, ba | bb});
            chk("model busy_cnt", {4'b0, busy_cnt}, {4'b0, exp_cnt()});
        end
    end

    task automatic drive(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                         input logic re, input logic [2:0] ra,
                         input logic [2:0] aa, input logic [2:0] ab);
        we = w; wr_addr = wa; wr_data = wd;
        resv_en = re; resv_addr = ra;
        rd_addr_a = aa; rd_addr_b = ab;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [2:0] aa, input logic [2:0] ab);
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, aa, ab);
    endtask

    initial begin
        // Reset held for two edges while a write is presented
        rst = 1'b0;
        drive(1'b1, 3'd3, 8'hFF, 1'b0, 3'd0, 3'd3, 3'd0);
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b1;
        idle(3'd3, 3'd0);
        @(negedge clk);
        chk("reset regs3", rd_data_a, 8'h00);
        chk("reset busy_cnt", {4'b0, busy_cnt}, 8'h00);
        chk("reset stall", {7'b0, stall}, 8'h00);
        tick();

        // Basic write and read
        drive(1'b1, 3'd2, 8'hA5, 1'b0, 3'd0, 3'd0, 3'd0);
        tick();
        drive(1'b1, 3'd7, 8'h3C, 1'b0, 3'd0, 3'd0, 3'd0);
        tick();
        idle(3'd2, 3'd7);
        @(negedge clk);
        chk("basic rd_data_a", rd_data_a, 8'hA5);
        chk("basic rd_data_b", rd_data_b, 8'h3C);
        chk("basic stall", {7'b0, stall}, 8'h00);
        tick();

        // R0 write and reserve are ignored
        drive(1'b1, 3'd0, 8'h55, 1'b1, 3'd0, 3'd0, 3'd0);
        @(negedge clk);
        chk("r0 rd_data_a", rd_data_a, 8'h00);
        chk("r0 rd_busy_a", {7'b0, rd_busy_a}, 8'h00);
        tick();
        idle(3'd0, 3'd0);
        @(negedge clk);
        chk("r0 busy_cnt", {4'b0, busy_cnt}, 8'h00);
        tick();

        // Hazard flow on R4
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd4, 3'd0);
        @(negedge clk);
        chk("resv same-cycle busy", {7'b0, rd_busy_a}, 8'h00);
        tick();
        idle(3'd4, 3'd0);
        @(negedge clk);
        chk("hazard rd_busy_a", {7'b0, rd_busy_a}, 8'h01);
        chk("hazard stall", {7'b0, stall}, 8'h01);
        chk("hazard busy_cnt", {4'b0, busy_cnt}, 8'h01);
        drive(1'b1, 3'd4, 8'h9E, 1'b0, 3'd0, 3'd4, 3'd0);
        @(negedge clk);
        chk("bypass rd_data_a", rd_data_a, 8'h9E);
        chk("bypass rd_busy_a", {7'b0, rd_busy_a}, 8'h00);
        chk("bypass stall", {7'b0, stall}, 8'h00);
        tick();
        idle(3'd4, 3'd0);
        @(negedge clk);
        chk("writeback busy_cnt", {4'b0, busy_cnt}, 8'h00);
        tick();

        // Simultaneous reserve and write to R5: reserve wins
        drive(1'b1, 3'd5, 8'h11, 1'b1, 3'd5, 3'd0, 3'd0);
        tick();
        idle(3'd5, 3'd0);
        @(negedge clk);
        chk("wr+resv rd_data_a", rd_data_a, 8'h11);
        chk("wr+resv rd_busy_a", {7'b0, rd_busy_a}, 8'h01);
        chk("wr+resv busy_cnt", {4'b0, busy_cnt}, 8'h01);
        tick();

        // Retire R5, then reserve R1, R3, R6 and reset mid-operation
        drive(1'b1, 3'd5, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
        tick();
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd0, 3'd0);
        tick();
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd0, 3'd0);
        tick();
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 3'd0, 3'd0);
        tick();
        idle(3'd1, 3'd6);
        @(negedge clk);
        chk("three resv busy_cnt", {4'b0, busy_cnt}, 8'h03);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mid reset busy_cnt", {4'b0, busy_cnt}, 8'h00);
        for (int a = 1; a < 8; a++) begin
            idle(3'(a), 3'(8 - a));
            #1;
            chk("mid reset busy flag", {7'b0, rd_busy_a}, 8'h00);
        end
        tick();
        drive(1'b1, 3'd3, 8'h07, 1'b0, 3'd0, 3'd0, 3'd0);
        tick();
        idle(3'd3, 3'd3);
        @(negedge clk);
        chk("post reset rd_data_a", rd_data_a, 8'h07);
        chk("post reset rd_busy_a", {7'b0, rd_busy_a}, 8'h00);
        tick();

        // Randomized traffic checked every cycle by the model comparison
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 59) != 0);
            drive(($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 8'($urandom),
                  ($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            tick();
        end
        rst = 1'b1;
        idle(3'd0, 3'd0);
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
